psr_cond_unit: RTL and testbench
================================

// Module: psr_cond_unit
// PURPOSE
//  Processor Status Register and branch-condition unit, directly downstream of the
//  ALU. Samples the ALU's 16-bit psr_flags, commits only the flags the executed
//  opcode owns, and evaluates the 4-bit Bcond/Jcond condition field against the
//  committed PSR. Also serves LPR/SPR (explicit PSR write/read) for the datapath.
// PARAMETERS
//  WIDTH          16  datapath and PSR width
//  ALU_CONT_BITS  5   alu_cont port is ALU_CONT_BITS+1 bits wide, matching the ALU
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-high
//  alu_cont    in   ALU_CONT_BITS+1  opcode currently driven into the ALU
//  psr_flags   in   WIDTH  ALU flag word: [7]N [6]Z [5]F [2]L [0]C, other bits 0
//  flag_en     in   1      ALU result commits this cycle; update owned flags
//  psr_we      in   1      LPR: load PSR from psr_wdata
//  psr_wdata   in   WIDTH  LPR data
//  cond_req    in   1      evaluate cond this cycle
//  cond        in   4      condition code
//  psr_q       out  WIDTH  committed PSR (SPR read path)
//  cond_valid  out  1      one-cycle pulse, result of cond_req from previous cycle
//  cond_taken  out  1      1 = condition true; held until next cond_valid
// BEHAVIOUR
//  - Reset (async, any time): psr_q=0, cond_valid=0, cond_taken=0. A request in
//    flight when reset asserts is dropped; no cond_valid follows.
//  - Writable bit mask 16'h00E5; psr_q bits outside mask always 0.
//  - Flag ownership on flag_en=1 (others hold):
//      5'b00011 ADD/ADDI/BCOND: C,F    5'b00100 SUB/SUBI: C,F
//      5'b00101 CMP/CMPI: N,Z,L        all other codes incl. 5'b01011 ADDU: none
//  - Priority: psr_we beats flag_en; LPR loads psr_wdata & 16'h00E5 in full.
//  - Update is registered: new PSR visible on psr_q the cycle after the edge.
//  - Cond eval: at edge with cond_req=1, cond_taken <= f(cond, psr_q before that
//    edge's update); cond_valid <= 1 for exactly one cycle. Latency 1.
//    Same-cycle flag_en/psr_we does NOT affect that evaluation (no bypass);
//    control must insert a cycle between CMP commit and dependent branch.
//  - Back-to-back cond_req accepted every cycle; cond_valid stays high.
//  - cond_req=0: cond_valid<=0, cond_taken holds.
//  - Cond table: 0 EQ Z  | 1 NE !Z | 2 CS C  | 3 CC !C | 4 HI L  | 5 LS !L
//    6 GT N | 7 LE !N | 8 FS F | 9 FC !F | A LO !L&!Z | B HS L|Z
//    C LT !N&!Z | D GE N|Z | E UC 1 | F never 0
// STRUCTURE
//  - Package bananachine_pkg: alu_cont opcode constants, PSR bit indices
//    (PSR_C=0, PSR_L=2, PSR_F=5, PSR_Z=6, PSR_N=7), PSR_MASK, cond-code localparams.
//  - Sub-module cond_eval (combinational: cond, psr -> taken); top holds PSR reg,
//    ownership decode and the 1-cycle result register.
// TESTING
//  1. Reset mid-run with psr_q=16'h00E5 and cond_req=1 -> psr_q=0, cond_valid=0
//     immediately and on next edge.
//  2. CMP flags psr_flags=16'h0044, flag_en=1 -> psr_q=16'h0044; then ADD with
//     psr_flags=16'h0021 -> psr_q=16'h0065 (N,Z,L... Z,L kept, C,F set).
//  3. ADDU (5'b01011) with psr_flags=16'h00E5, flag_en=1 -> psr_q unchanged.
//  4. psr_we=1 and flag_en=1 same edge, psr_wdata=16'hFFFF -> psr_q=16'h00E5.
//  5. psr_q=16'h0040; cond_req with cond=0,1,A,B,E,F on 6 consecutive cycles ->
//     cond_valid high 6 cycles, cond_taken=1,0,0,1,1,0.
//  6. cond_req (EQ) on same edge as CMP commit setting Z from 0 -> cond_taken=0;
//     repeat next cycle -> cond_taken=1.

Source files
------------

// File: rtl/bananachine_pkg.sv
// Shared constants for the PSR/condition path: ALU opcodes that own flags,
// PSR bit positions, the writable-bit mask and the Bcond/Jcond encodings.
package bananachine_pkg;

  localparam int WIDTH         = 16;
  localparam int ALU_CONT_BITS = 5;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_ADDU = 5'b01011;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  localparam logic [15:0] PSR_MASK = 16'h00E5;

  localparam logic [15:0] OWN_ADD_SUB = (16'h1 << PSR_C) | (16'h1 << PSR_F);
  localparam logic [15:0] OWN_CMP     = (16'h1 << PSR_N) | (16'h1 << PSR_Z) |
                                        (16'h1 << PSR_L);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_HI = 4'h4,
    COND_LS = 4'h5,
    COND_GT = 4'h6,
    COND_LE = 4'h7,
    COND_FS = 4'h8,
    COND_FC = 4'h9,
    COND_LO = 4'hA,
    COND_HS = 4'hB,
    COND_LT = 4'hC,
    COND_GE = 4'hD,
    COND_UC = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/psr_cond_unit_cond_eval.sv
// Combinational Bcond/Jcond evaluator: maps a 4-bit condition code and the
// five architectural flags onto a single taken/not-taken decision.
module cond_eval
  import bananachine_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       flagN,
  input  logic       flagZ,
  input  logic       flagF,
  input  logic       flagL,
  input  logic       flagC,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = flagZ;
      COND_NE: taken = ~flagZ;
      COND_CS: taken = flagC;
      COND_CC: taken = ~flagC;
      COND_HI: taken = flagL;
      COND_LS: taken = ~flagL;
      COND_GT: taken = flagN;
      COND_LE: taken = ~flagN;
      COND_FS: taken = flagF;
      COND_FC: taken = ~flagF;
      COND_LO: taken = ~flagL & ~flagZ;
      COND_HS: taken = flagL | flagZ;
      COND_LT: taken = ~flagN & ~flagZ;
      COND_GE: taken = flagN | flagZ;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond_unit.sv
// Processor status register plus branch-condition result register. Commits
// only the flags owned by the current ALU opcode; LPR overrides flag commits.
module psr_cond_unit
  import bananachine_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ALU_CONT_BITS:0]   alu_cont,
  input  logic [WIDTH-1:0]         psr_flags,
  input  logic                     flag_en,
  input  logic                     psr_we,
  input  logic [WIDTH-1:0]         psr_wdata,
  input  logic                     cond_req,
  input  logic [3:0]               cond,
  output logic [WIDTH-1:0]         psr_q,
  output logic                     cond_valid,
  output logic                     cond_taken
);

  localparam logic [WIDTH-1:0] MASK_W    = WIDTH'(PSR_MASK);
  localparam logic [WIDTH-1:0] OWN_AS_W  = WIDTH'(OWN_ADD_SUB);
  localparam logic [WIDTH-1:0] OWN_CMP_W = WIDTH'(OWN_CMP);

  logic [WIDTH-1:0] psrReg_q;
  logic [WIDTH-1:0] psr_d;
  logic [WIDTH-1:0] ownMask;
  logic             condValid_q;
  logic             condTaken_q;
  logic             takenNow;

  // Opcodes compare against the full port width, so codes with the top bit set own nothing.
  always_comb begin
    ownMask = '0;
    if (alu_cont == (ALU_CONT_BITS+1)'(OP_ADD) || alu_cont == (ALU_CONT_BITS+1)'(OP_SUB)) begin
      ownMask = OWN_AS_W;
    end else if (alu_cont == (ALU_CONT_BITS+1)'(OP_CMP)) begin
      ownMask = OWN_CMP_W;
    end
  end

  always_comb begin
    psr_d = psrReg_q;
    if (psr_we) begin
      psr_d = psr_wdata & MASK_W;
    end else if (flag_en) begin
      psr_d = ((psrReg_q & ~ownMask) | (psr_flags & ownMask)) & MASK_W;
    end
  end

  // Evaluated from the committed PSR only; a same-edge commit is deliberately not bypassed.
  cond_eval uCondEval (
    .cond  (cond),
    .flagN (psrReg_q[PSR_N]),
    .flagZ (psrReg_q[PSR_Z]),
    .flagF (psrReg_q[PSR_F]),
    .flagL (psrReg_q[PSR_L]),
    .flagC (psrReg_q[PSR_C]),
    .taken (takenNow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psrReg_q    <= '0;
      condValid_q <= 1'b0;
      condTaken_q <= 1'b0;
    end else begin
      psrReg_q    <= psr_d;
      condValid_q <= cond_req;
      if (cond_req) begin
        condTaken_q <= takenNow;
      end
    end
  end

  assign psr_q      = psrReg_q;
  assign cond_valid = condValid_q;
  assign cond_taken = condTaken_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Scoreboard bench for psr_cond_unit: directed scenarios followed by random
// traffic, checked against a flag-level reference model.
module tb_psr_cond_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  alu_cont;
  logic [15:0] psr_flags;
  logic        flag_en;
  logic        psr_we;
  logic [15:0] psr_wdata;
  logic        cond_req;
  logic [3:0]  cond;
  logic [15:0] psr_q;
  logic        cond_valid;
  logic        cond_taken;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] modelPsr = 16'h0000;
  bit          expQ[$];

  psr_cond_unit dut (
    .clk        (clk),
    .reset      (reset),
    .alu_cont   (alu_cont),
    .psr_flags  (psr_flags),
    .flag_en    (flag_en),
    .psr_we     (psr_we),
    .psr_wdata  (psr_wdata),
    .cond_req   (cond_req),
    .cond       (cond),
    .psr_q      (psr_q),
    .cond_valid (cond_valid),
    .cond_taken (cond_taken)
  );

  always #5 clk = ~clk;

  function automatic bit refCond(input logic [3:0] c, input logic [15:0] p);
    bit n, z, f, l, cy;
    n = p[7]; z = p[6]; f = p[5]; l = p[2]; cy = p[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return l;
      4'h5: return !l;
      4'h6: return n;
      4'h7: return !n;
      4'h8: return f;
      4'h9: return !f;
      4'hA: return !(l || z);
      4'hB: return l || z;
      4'hC: return !(n || z);
      4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] refPsr(input logic [15:0] p, input logic [5:0] op,
                                         input logic [15:0] fl, input bit en,
                                         input bit we, input logic [15:0] wd);
    int owned[$];
    logic [15:0] r;
    r = p;
    if (we) return wd & 16'h00E5;
    if (!en) return p;
    if (op == 6'd3 || op == 6'd4) owned = '{0, 5};
    else if (op == 6'd5) owned = '{7, 6, 2};
    foreach (owned[i]) r[owned[i]] = fl[owned[i]];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, settle 1ns past it.
  task automatic applyStimulus(input logic [5:0] op, input logic [15:0] fl, input bit en,
                               input bit we, input logic [15:0] wd,
                               input bit req, input logic [3:0] c);
    alu_cont = op; psr_flags = fl; flag_en = en;
    psr_we = we; psr_wdata = wd; cond_req = req; cond = c;
    @(posedge clk);
    if (reset) begin
      modelPsr = 16'h0000;
    end else begin
      if (req) expQ.push_back(refCond(c, modelPsr));
      modelPsr = refPsr(modelPsr, op, fl, en, we, wd);
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(6'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
  endtask

  always @(negedge clk) begin
    checkOutput("psr_q", psr_q, modelPsr);
    if (cond_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_cond_valid", 16'(cond_valid), 16'h0);
      end else begin
        checkOutput("cond_taken", 16'(cond_taken), 16'(expQ.pop_front()));
      end
    end else if (expQ.size() != 0) begin
      void'(expQ.pop_front());
      checkOutput("missing_cond_valid", 16'(cond_valid), 16'h1);
    end
  end

  initial begin
    bit tk[6];
    logic [3:0] cs[6];
    reset = 1'b1;
    alu_cont = '0; psr_flags = '0; flag_en = 0; psr_we = 0;
    psr_wdata = '0; cond_req = 0; cond = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_psr", psr_q, 16'h0000);
    checkOutput("reset_valid", 16'(cond_valid), 16'h0);
    checkOutput("reset_taken", 16'(cond_taken), 16'h0);
    reset = 1'b0;
    idle();

    applyStimulus(6'd5, 16'h0044, 1, 0, 16'h0, 0, 4'h0);
    checkOutput("cmp_commit", psr_q, 16'h0044);
    applyStimulus(6'd3, 16'h0021, 1, 0, 16'h0, 0, 4'h0);
    checkOutput("add_commit", psr_q, 16'h0065);
    applyStimulus(6'd11, 16'h00E5, 1, 0, 16'h0, 0, 4'h0);
    checkOutput("addu_noflags", psr_q, 16'h0065);
    applyStimulus(6'd5, 16'h0000, 1, 1, 16'hFFFF, 0, 4'h0);
    checkOutput("lpr_priority", psr_q, 16'h00E5);

    // Reset asserted mid-cycle while a condition result is in flight.
    applyStimulus(6'd0, 16'h0, 0, 0, 16'h0, 1, 4'hE);
    #2;
    reset = 1'b1;
    modelPsr = 16'h0000;
    expQ.delete();
    #1;
    checkOutput("async_reset_psr", psr_q, 16'h0000);
    checkOutput("async_reset_valid", 16'(cond_valid), 16'h0);
    applyStimulus(6'd0, 16'h0, 0, 0, 16'h0, 1, 4'hE);
    checkOutput("reset_edge_valid", 16'(cond_valid), 16'h0);
    reset = 1'b0;
    idle();

    applyStimulus(6'd0, 16'h0, 0, 1, 16'h0040, 0, 4'h0);
    cs = '{4'h0, 4'h1, 4'hA, 4'hB, 4'hE, 4'hF};
    tk = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (cs[i]) begin
      applyStimulus(6'd0, 16'h0, 0, 0, 16'h0, 1, cs[i]);
      checkOutput("b2b_valid", 16'(cond_valid), 16'h1);
      checkOutput("b2b_taken", 16'(cond_taken), 16'(tk[i]));
    end
    idle();
    checkOutput("valid_drop", 16'(cond_valid), 16'h0);
    checkOutput("taken_hold", 16'(cond_taken), 16'h0);

    applyStimulus(6'd0, 16'h0, 0, 1, 16'h0000, 0, 4'h0);
    applyStimulus(6'd5, 16'h0040, 1, 0, 16'h0, 1, 4'h0);
    checkOutput("no_bypass", 16'(cond_taken), 16'h0);
    applyStimulus(6'd0, 16'h0, 0, 0, 16'h0, 1, 4'h0);
    checkOutput("after_commit", 16'(cond_taken), 16'h1);
    idle();

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 4))
        0: op = 6'd3;
        1: op = 6'd4;
        2: op = 6'd5;
        3: op = 6'd11;
        default: op = 6'($urandom_range(0, 31));
      endcase
      applyStimulus(op, 16'($urandom) & 16'h00E5, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), 16'($urandom),
                    ($urandom_range(0, 3) != 0), 4'($urandom));
    end
    idle();
    idle();
    checkOutput("queue_drained", 16'(expQ.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
